mem_access_sequencer: RTL and testbench
=======================================

Name: mem_access_sequencer

Overview:
- Multi-cycle sequencer that executes one load/store instruction (lb, lbu, lh, lhu, lw, sb, sh, sw) against a byte-wide data memory.
- Decodes the 6-bit MIPS opcode, issues 1/2/4 byte transfers with a request/ready handshake, assembles and extends load data, and pulses done.
- Sits between the core control/datapath and the data memory. It replaces the single-cycle 32-bit memory port when the memory is byte-wide.

Parameters:
- ADDR_W, 32, byte address width.
- WAIT_LIMIT, 15, max cycles allowed waiting on mem_ready per byte before abort (counter width = $clog2(WAIT_LIMIT+1)).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin an access; sampled only in IDLE.
- OpCode  in  6  instruction opcode: lb=100000, lh=100001, lw=100011, lbu=100100, lhu=100101, sb=101000, sh=101001, sw=101011.
- addr  in  ADDR_W  effective byte address.
- wdata  in  32  store data (rt value).
- busy  out  1  high from the cycle after accepted start until done/err.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse with done on illegal opcode or timeout.
- rdata  out  32  extended load result; valid from done, held until next accepted start.
- mem_req  out  1  byte transfer request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  out  ADDR_W  byte address of current transfer.
- mem_wdata  out  8  write byte.
- mem_rdata  in  8  read byte, valid when mem_ready.
- mem_ready  in  1  transfer complete this cycle.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, err, mem_req, mem_we = 0; mem_addr, mem_wdata, rdata = 0; counters = 0.
- States: IDLE, XFER, FINISH.
- IDLE:
  - On start=1, latch OpCode, addr, wdata, and set busy next cycle.
  - Size n: 1 for b/bu, 2 for h/hu, 4 for w.
  - Illegal opcode (anything else, including lui 001111): go to FINISH with err set. No mem_req is ever asserted.
  - Otherwise go to XFER with byte index i=0.
- XFER:
  - Drive mem_req=1, mem_we=store, and mem_addr = base + i.
  - Base is addr with low bits cleared to the size alignment (see Optional Feature).
  - Big-endian: i=0 is the MSB of the transferred field.
  - Store byte = wdata byte (n-1-i) of the low n bytes; sw i=0 sends wdata[31:24], sb sends wdata[7:0].
  - On mem_ready: for loads, shift mem_rdata into an assembly register. Reset the wait counter. If i==n-1 go to FINISH, else i++ (mem_req stays high, address advances next cycle).
  - Each cycle without mem_ready increments the wait counter. When it reaches WAIT_LIMIT: drop mem_req, set err, go to FINISH.
- FINISH (1 cycle): done=1, busy=0, mem_req=0.
  - rdata: lb/lh sign-extend; lbu/lhu zero-extend; lw passes through. Stores leave rdata unchanged.
  - Next state is IDLE.
- Latency with zero-wait memory: start to done = n+2 cycles (lw: 6, sb: 3). Illegal opcode: 2 cycles.
- start while busy is ignored. start in the FINISH cycle is ignored; a new access may start the cycle after done.
- Reset mid-operation: immediate return to IDLE, mem_req drops asynchronously, no done pulse.
- mem_ready while mem_req=0 is ignored.

Optional Feature:
- Macro MEM_SEQ_MISALIGN_TRAP_EN.
- Defined: in IDLE, addr not aligned to the size (h: addr[0]!=0; w: addr[1:0]!=0) gives FINISH with err=1 and no memory transfer.
- Undefined: low address bits are silently masked (h: addr[0]=0, w: addr[1:0]=00) and the access proceeds normally.

Test Plan:
- lw at addr 0x100, memory bytes 0x100..0x103 = 12,34,56,78, zero wait -> mem_addr 100,101,102,103; rdata=0x12345678; done 6 cycles after start; err=0.
- lb at 0x200 = 0x80, then lbu at 0x200 -> rdata 0xFFFFFF80, then 0x00000080. lh at 0x202 = 0xFF,0x01 -> 0xFFFF FF01.
- sh wdata=0xDEADBEEF at 0x10, mem_ready delayed 3 cycles per byte -> writes BE@0x10 then EF@0x11; mem_req held during waits; done after 2+2*4 cycles.
- OpCode=001111 (lui) with start -> no mem_req, done=1 and err=1 two cycles after start; rdata unchanged.
- sw with mem_ready stuck 0 -> err+done after WAIT_LIMIT=15 wait cycles; mem_req low afterward; next lw completes normally.
- Assert rst_n=0 in XFER of a lw -> mem_req/busy to 0 immediately, no done. lh at 0x3 -> trap err with the macro; access 0x2/0x3 without it.

Source files
------------

// File: rtl/mem_access_sequencer.sv
// Byte-serial load/store sequencer: runs one MIPS lb/lbu/lh/lhu/lw/sb/sh/sw against a byte-wide memory.
// Define MEM_SEQ_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of masking the address.
module mem_access_sequencer #(
  parameter int ADDR_W     = 32,
  parameter int WAIT_LIMIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [5:0]        OpCode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready
);

  localparam int WW = $clog2(WAIT_LIMIT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_LIMIT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, FINISH = 2'd2} state_t;

  // Returns {valid, store, signed, last byte index}
  function automatic logic [4:0] decode(input logic [5:0] op);
    case (op)
      6'b100000: decode = {1'b1, 1'b0, 1'b1, 2'd0};
      6'b100001: decode = {1'b1, 1'b0, 1'b1, 2'd1};
      6'b100011: decode = {1'b1, 1'b0, 1'b0, 2'd3};
      6'b100100: decode = {1'b1, 1'b0, 1'b0, 2'd0};
      6'b100101: decode = {1'b1, 1'b0, 1'b0, 2'd1};
      6'b101000: decode = {1'b1, 1'b1, 1'b0, 2'd0};
      6'b101001: decode = {1'b1, 1'b1, 1'b0, 2'd1};
      6'b101011: decode = {1'b1, 1'b1, 1'b0, 2'd3};
      default:   decode = 5'd0;
    endcase
  endfunction

  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] k);
    case (k)
      2'd0:    pick_byte = w[7:0];
      2'd1:    pick_byte = w[15:8];
      2'd2:    pick_byte = w[23:16];
      default: pick_byte = w[31:24];
    endcase
  endfunction

  state_t            state_q, state_d;
  logic              store_q, store_d;
  logic              signed_q, signed_d;
  logic [1:0]        last_q, last_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       asm_q, asm_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic              err_pend_q, err_pend_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;

  logic [4:0]        dec_s;
  logic [1:0]        nxt_idx_s;
  logic [ADDR_W-1:0] aligned_s;
  logic [31:0]       ext_s;

  // Next-state and next-output computation for the whole sequencer
  always_comb begin
    state_d     = state_q;
    store_d     = store_q;
    signed_d    = signed_q;
    last_d      = last_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    wait_d      = wait_q;
    err_pend_d  = err_pend_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    dec_s     = decode(OpCode);
    nxt_idx_s = idx_q + 2'd1;
    aligned_s = addr & ~{{(ADDR_W-2){1'b0}}, dec_s[1:0]};

    case (last_q)
      2'd0:    ext_s = signed_q ? {{24{asm_q[7]}}, asm_q[7:0]} : {24'd0, asm_q[7:0]};
      2'd1:    ext_s = signed_q ? {{16{asm_q[15]}}, asm_q[15:0]} : {16'd0, asm_q[15:0]};
      default: ext_s = asm_q;
    endcase

    case (state_q)
      IDLE: begin
        // A start coinciding with the done pulse is dropped; the next cycle may start
        if (start && !done_q) begin
          store_d  = dec_s[3];
          signed_d = dec_s[2];
          last_d   = dec_s[1:0];
          wdata_d  = wdata;
          idx_d    = 2'd0;
          asm_d    = 32'd0;
          wait_d   = '0;
          busy_d   = 1'b1;
          if (!dec_s[4]) begin
            state_d    = FINISH;
            err_pend_d = 1'b1;
          end
`ifdef MEM_SEQ_MISALIGN_TRAP_EN
          else if ((addr[1:0] & dec_s[1:0]) != 2'd0) begin
            state_d    = FINISH;
            err_pend_d = 1'b1;
          end
`endif
          else begin
            state_d     = XFER;
            err_pend_d  = 1'b0;
            mem_req_d   = 1'b1;
            mem_we_d    = dec_s[3];
            mem_addr_d  = aligned_s;
            mem_wdata_d = pick_byte(wdata, dec_s[1:0]);
          end
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        if (mem_ready) begin
          wait_d = '0;
          if (!store_q) begin
            asm_d = {asm_q[23:0], mem_rdata};
          end else begin
            asm_d = asm_q;
          end
          if (idx_q == last_q) begin
            state_d   = FINISH;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
          end else begin
            idx_d       = nxt_idx_s;
            mem_addr_d  = mem_addr_q + ADDR_W'(1);
            mem_wdata_d = pick_byte(wdata_q, last_q - nxt_idx_s);
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d    = FINISH;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          err_pend_d = 1'b1;
          wait_d     = '0;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      FINISH: begin
        state_d    = IDLE;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        err_d      = err_pend_q;
        err_pend_d = 1'b0;
        mem_req_d  = 1'b0;
        mem_we_d   = 1'b0;
        // Failed accesses and stores keep the previous load result
        if (!err_pend_q && !store_q) begin
          rdata_d = ext_s;
        end else begin
          rdata_d = rdata_q;
        end
      end
      default: begin
        state_d   = IDLE;
        busy_d    = 1'b0;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      store_q     <= 1'b0;
      signed_q    <= 1'b0;
      last_q      <= 2'd0;
      idx_q       <= 2'd0;
      wdata_q     <= 32'd0;
      asm_q       <= 32'd0;
      wait_q      <= '0;
      err_pend_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 32'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      store_q     <= store_d;
      signed_q    <= signed_d;
      last_q      <= last_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      asm_q       <= asm_d;
      wait_q      <= wait_d;
      err_pend_q  <= err_pend_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer: vector table plus hand sequences for timeout, reset and misalignment.
module tb_mem_access_sequencer;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_LUI = 6'b001111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  op = 6'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_ready;

  mem_access_sequencer #(.ADDR_W(32), .WAIT_LIMIT(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .OpCode(op), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Byte memory with programmable ready delay
  logic [7:0]  mem [0:1023];
  int          dly = 0;
  logic        stuck = 1'b0;
  int          wcnt = 0;
  int          req_cycles = 0;
  logic [31:0] addr_log [$];

  assign mem_ready = mem_req && !stuck && (wcnt == dly);
  assign mem_rdata = mem[mem_addr[9:0]];

  always @(posedge clk) begin
    if (!mem_req || mem_ready) wcnt <= 0;
    else wcnt <= wcnt + 1;
    if (mem_req) req_cycles <= req_cycles + 1;
    if (mem_req && mem_ready) begin
      addr_log.push_back(mem_addr);
      if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one access and wait (bounded) for done; cyc counts cycles from start to done
  task automatic run_access(input logic [5:0] o, input logic [31:0] a, input logic [31:0] w,
                            input int max, output int cyc, output logic got, output logic b1);
    @(negedge clk);
    start = 1'b1; op = o; addr = a; wdata = w;
    req_cycles = 0;
    addr_log.delete();
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    b1 = busy;
    while (!done && cyc < max) begin
      @(negedge clk);
      cyc++;
    end
    got = done;
  endtask

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    int          dly;
    int          cyc;
    logic        err;
    logic [31:0] rd;
    int          reqs;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int   cyc;
    logic got, b1;

    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h100] = 8'h12; mem[10'h101] = 8'h34; mem[10'h102] = 8'h56; mem[10'h103] = 8'h78;
    mem[10'h200] = 8'h80; mem[10'h202] = 8'hFF; mem[10'h203] = 8'h01;
    mem[10'h002] = 8'h7F; mem[10'h003] = 8'h80;

    tbl[0]  = '{"lw",      OP_LW,  32'h100, 32'h0,        0, 6,  1'b0, 32'h12345678, 4};
    tbl[1]  = '{"lb",      OP_LB,  32'h200, 32'h0,        0, 3,  1'b0, 32'hFFFFFF80, 1};
    tbl[2]  = '{"lbu",     OP_LBU, 32'h200, 32'h0,        0, 3,  1'b0, 32'h00000080, 1};
    tbl[3]  = '{"lh",      OP_LH,  32'h202, 32'h0,        0, 4,  1'b0, 32'hFFFFFF01, 2};
    tbl[4]  = '{"lhu",     OP_LHU, 32'h202, 32'h0,        0, 4,  1'b0, 32'h0000FF01, 2};
    tbl[5]  = '{"sh_wait", OP_SH,  32'h10,  32'hDEADBEEF, 3, 10, 1'b0, 32'h0000FF01, 8};
    tbl[6]  = '{"lui",     OP_LUI, 32'h10,  32'h0,        0, 2,  1'b1, 32'h0000FF01, 0};
    tbl[7]  = '{"lhu_rb",  OP_LHU, 32'h10,  32'h0,        0, 4,  1'b0, 32'h0000BEEF, 2};
    tbl[8]  = '{"sw",      OP_SW,  32'h20,  32'hCAFEF00D, 0, 6,  1'b0, 32'h0000BEEF, 4};
    tbl[9]  = '{"lw_rb",   OP_LW,  32'h20,  32'h0,        0, 6,  1'b0, 32'hCAFEF00D, 4};
    tbl[10] = '{"sb",      OP_SB,  32'h31,  32'h123456A5, 0, 3,  1'b0, 32'hCAFEF00D, 1};
    tbl[11] = '{"lb_rb",   OP_LB,  32'h31,  32'h0,        0, 3,  1'b0, 32'hFFFFFFA5, 1};
    tbl[12] = '{"lw_dly1", OP_LW,  32'h100, 32'h0,        1, 10, 1'b0, 32'h12345678, 8};

    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      dly = tbl[i].dly;
      run_access(tbl[i].op, tbl[i].addr, tbl[i].wd, 40, cyc, got, b1);
      chk({tbl[i].name, "_done"}, {31'd0, got}, 32'd1);
      chk({tbl[i].name, "_busy"}, {31'd0, b1}, 32'd1);
      chk({tbl[i].name, "_cycles"}, cyc, tbl[i].cyc);
      chk({tbl[i].name, "_err"}, {31'd0, err}, {31'd0, tbl[i].err});
      chk({tbl[i].name, "_rdata"}, rdata, tbl[i].rd);
      chk({tbl[i].name, "_req_cycles"}, req_cycles, tbl[i].reqs);
      if (i == 0) begin
        chk("lw_addr_count", addr_log.size(), 32'd4);
        for (int k = 0; k < 4; k++)
          if (k < addr_log.size()) chk("lw_addr_seq", addr_log[k], 32'h100 + k);
      end
      if (i == 5) begin
        chk("sh_byte0", {24'd0, mem[10'h010]}, 32'hBE);
        chk("sh_byte1", {24'd0, mem[10'h011]}, 32'hEF);
      end
      @(negedge clk);
      chk({tbl[i].name, "_done_pulse"}, {31'd0, done}, 32'd0);
      chk({tbl[i].name, "_busy_after"}, {31'd0, busy}, 32'd0);
    end
    dly = 0;

    // Stuck memory: abort after WAIT_LIMIT wait cycles, then recover
    stuck = 1'b1;
    run_access(OP_SW, 32'h40, 32'h11223344, 40, cyc, got, b1);
    chk("tmo_done", {31'd0, got}, 32'd1);
    chk("tmo_err", {31'd0, err}, 32'd1);
    chk("tmo_req_cycles", req_cycles, 32'd15);
    chk("tmo_cycles", cyc, 32'd17);
    chk("tmo_mem_req_low", {31'd0, mem_req}, 32'd0);
    chk("tmo_no_write", {24'd0, mem[10'h040]}, 32'd0);
    stuck = 1'b0;
    @(negedge clk);
    run_access(OP_LW, 32'h100, 32'h0, 40, cyc, got, b1);
    chk("post_tmo_done", {31'd0, got}, 32'd1);
    chk("post_tmo_err", {31'd0, err}, 32'd0);
    chk("post_tmo_rdata", rdata, 32'h12345678);
    chk("post_tmo_cycles", cyc, 32'd6);
    @(negedge clk);

    // Reset during XFER of a lw
    stuck = 1'b1;
    @(negedge clk);
    start = 1'b1; op = OP_LW; addr = 32'h100;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_rst_mem_req", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    got = 1'b0;
    stuck = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk("rst_mid_no_done", {31'd0, got}, 32'd0);
    chk("rst_mid_rdata", rdata, 32'd0);

    // Misaligned halfword at 0x3
    run_access(OP_LH, 32'h3, 32'h0, 40, cyc, got, b1);
    chk("mis_done", {31'd0, got}, 32'd1);
`ifdef MEM_SEQ_MISALIGN_TRAP_EN
    chk("mis_err", {31'd0, err}, 32'd1);
    chk("mis_cycles", cyc, 32'd2);
    chk("mis_req_cycles", req_cycles, 32'd0);
    chk("mis_rdata", rdata, 32'd0);
`else
    chk("mis_err", {31'd0, err}, 32'd0);
    chk("mis_cycles", cyc, 32'd4);
    chk("mis_rdata", rdata, 32'h00007F80);
    chk("mis_addr_count", addr_log.size(), 32'd2);
    if (addr_log.size() == 2) begin
      chk("mis_addr0", addr_log[0], 32'h2);
      chk("mis_addr1", addr_log[1], 32'h3);
    end
`endif
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
